// File: rtl/uart_arb_pkg.sv
// Shared types and helpers for the UART transmit arbiter.
package uart_arb_pkg;

    localparam int BYTE_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        SEND = 2'd1,
        GAP  = 2'd2
    } arb_state_e;

    // Base bit of requester k's byte inside the flattened data bus.
    function automatic int byte_base(input int k);
        return BYTE_W * k;
    endfunction

endpackage

// File: rtl/uart_rr_pick.sv
// Combinational round-robin selector: first set req bit after 'last', wrapping mod N.
module uart_rr_pick
    import uart_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IdxW = 2
) (
    input  logic [0:N-1]    req,
    input  logic [IdxW-1:0] last,
    output logic            valid,
    output logic [IdxW-1:0] idx
);

    // Scan from farthest to nearest so the nearest candidate after 'last' wins.
    // The wrap is an explicit compare against N, so N need not be a power of two.
    always_comb begin
        int cand;
        cand  = 0;
        valid = 1'b0;
        idx   = '0;
        for (int i = N; i >= 1; i--) begin
            cand = int'(last) + i;
            if (cand >= N) begin
                cand = cand - N;
            end
            if (req[IdxW'(cand)]) begin
                valid = 1'b1;
                idx   = IdxW'(cand);
            end
        end
    end

endmodule

// File: rtl/uart_tx_arb.sv
// Round-robin arbiter sharing one UART transmitter among N byte producers.
// Optional build macro UART_ARB_LOCK_EN adds a per-requester lock input that
// keeps the grant on the same requester across bytes of a multi-byte message.
//
// state | meaning
// IDLE  | no byte in flight; arbitrate among pending requests
// SEND  | granted byte presented to the uart, send held until done
// GAP   | one cycle with send low, ack pulses to the served requester
module uart_tx_arb
    import uart_arb_pkg::*;
#(
    parameter int N    = 4,
    parameter int IdxW = 2
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [0:N-1]          req,
    input  logic [0:BYTE_W*N-1]   data,
`ifdef UART_ARB_LOCK_EN
    input  logic [0:N-1]          lock,
`endif
    output logic [0:N-1]          ack,
    output logic [IdxW-1:0]       gnt,
    output logic                  busy,
    output logic [0:BYTE_W-1]     uart_din,
    output logic                  uart_send,
    input  logic                  uart_done
);

    arb_state_e          state_q, state_n;
    logic [IdxW-1:0]     last_q, last_n;
    logic [IdxW-1:0]     gnt_n;
    logic [0:N-1]        ack_n;
    logic                busy_n;
    logic [0:BYTE_W-1]   din_n;
    logic                send_n;
    logic                pick_valid;
    logic [IdxW-1:0]     pick_idx;

    uart_rr_pick #(
        .N    (N),
        .IdxW (IdxW)
    ) u_pick (
        .req   (req),
        .last  (last_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and registered outputs; reset returns to IDLE with requester 0 first in line.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q   <= IDLE;
            last_q    <= IdxW'(N - 1);
            gnt       <= '0;
            ack       <= '0;
            busy      <= 1'b0;
            uart_din  <= '0;
            uart_send <= 1'b0;
        end else begin
            state_q   <= state_n;
            last_q    <= last_n;
            gnt       <= gnt_n;
            ack       <= ack_n;
            busy      <= busy_n;
            uart_din  <= din_n;
            uart_send <= send_n;
        end
    end

    // Next-state and next-output logic; everything holds unless a transition changes it.
    always_comb begin
        state_n = state_q;
        last_n  = last_q;
        gnt_n   = gnt;
        ack_n   = '0;
        busy_n  = busy;
        din_n   = uart_din;
        send_n  = uart_send;
        case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    gnt_n   = pick_idx;
                    last_n  = pick_idx;
                    din_n   = data[byte_base(int'(pick_idx)) +: BYTE_W];
                    busy_n  = 1'b1;
                    send_n  = 1'b1;
                    state_n = SEND;
                end
            end
            SEND: begin
                if (uart_done) begin
                    ack_n[gnt] = 1'b1;
                    send_n     = 1'b0;
                    busy_n     = 1'b0;
                    state_n    = GAP;
`ifdef UART_ARB_LOCK_EN
                    // Point 'last' just behind the current grant so it is searched first.
                    if (lock[gnt]) begin
                        last_n = (gnt == '0) ? IdxW'(N - 1) : gnt - IdxW'(1);
                    end
`endif
                end
            end
            GAP: begin
                state_n = IDLE;
            end
            default: begin
                state_n = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_uart_tx_arb.sv
// Self-checking bench for uart_tx_arb: directed scenarios plus randomized traffic
// compared against a round-robin reference model.
module tb_uart_tx_arb;

    localparam int N  = 4;
    localparam int IW = 2;

    logic              clk = 1'b0;
    logic              reset;
    logic [0:N-1]      req;
    logic [0:8*N-1]    data;
    logic [0:N-1]      ack;
    logic [IW-1:0]     gnt;
    logic              busy;
    logic [0:7]        uart_din;
    logic              uart_send;
    logic              uart_done;
`ifdef UART_ARB_LOCK_EN
    logic [0:N-1]      lock;
`endif

    int n_cmp = 0;
    int n_err = 0;
    int m_last;

    always #5 clk = ~clk;

    uart_tx_arb #(
        .N    (N),
        .IdxW (IW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .req       (req),
        .data      (data),
`ifdef UART_ARB_LOCK_EN
        .lock      (lock),
`endif
        .ack       (ack),
        .gnt       (gnt),
        .busy      (busy),
        .uart_din  (uart_din),
        .uart_send (uart_send),
        .uart_done (uart_done)
    );

    task automatic chk_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    // Reference: first pending requester after the last served one, wrapping mod N.
    function automatic int model_pick();
        for (int j = 1; j <= N; j++) begin
            int k;
            k = (m_last + j) % N;
            if (req[k]) return k;
        end
        return -1;
    endfunction

    function automatic logic [7:0] byte_of(input int k);
        logic [7:0] b;
        b = data[8*k +: 8];
        return b;
    endfunction

    task automatic set_byte(input int k, input logic [7:0] b);
        data[8*k +: 8] = b;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        tick();
        chk_eq("rst_send", 32'(uart_send), 0);
        chk_eq("rst_busy", 32'(busy), 0);
        chk_eq("rst_ack", 32'(ack), 0);
        chk_eq("rst_gnt", 32'(gnt), 0);
        reset = 1'b0;
        m_last = N - 1;
    endtask

    // Called at a negedge with the DUT idle and req already set; returns in the GAP cycle.
    task automatic serve(input int dly, input bit drop_mid, input bit rnd, input bit late_done,
                         output int k);
        logic [7:0]   eb;
        logic [0:N-1] ea;
        int           drops;
        k = model_pick();
        if (k < 0) begin
            n_cmp++;
            n_err++;
            $display("FAIL pick: no request pending for arbitration");
            k = 0;
            return;
        end
        eb = byte_of(k);
        tick();
        chk_eq("send_rise", 32'(uart_send), 1);
        chk_eq("busy_set", 32'(busy), 1);
        chk_eq("gnt", 32'(gnt), k);
        chk_eq("din", 32'(uart_din), 32'(eb));
        m_last = k;
        drops = 0;
        for (int c = 0; c < dly; c++) begin
            if (c == 0) begin
                if (drop_mid) req[k] = 1'b0;
                if (rnd) set_byte(k, ~eb);
            end
            if (rnd) begin
                for (int j = 0; j < N; j++) begin
                    if (j != k && !req[j] && $urandom_range(0, 3) == 0) begin
                        set_byte(j, 8'($urandom));
                        req[j] = 1'b1;
                    end
                end
            end
            tick();
            if (uart_send !== 1'b1 || uart_din !== eb || busy !== 1'b1) drops++;
        end
        chk_eq("send_held", drops, 0);
        uart_done = 1'b1;
        tick();
        if (!late_done) uart_done = 1'b0;
        ea = '0;
        ea[k] = 1'b1;
        chk_eq("ack_pulse", 32'(ack), 32'(ea));
        chk_eq("send_drop", 32'(uart_send), 0);
        chk_eq("busy_drop", 32'(busy), 0);
`ifdef UART_ARB_LOCK_EN
        if (lock[k]) m_last = (k + N - 1) % N;
`endif
    endtask

    // From the GAP cycle into IDLE: ack must be gone and send still low.
    task automatic to_idle();
        tick();
        uart_done = 1'b0;
        chk_eq("ack_single", 32'(ack), 0);
        chk_eq("gap_low", 32'(uart_send), 0);
    endtask

    initial begin
        int k;
        reset     = 1'b1;
        req       = '0;
        data      = '0;
        uart_done = 1'b0;
`ifdef UART_ARB_LOCK_EN
        lock      = '0;
`endif
        tick();
        tick();
        chk_eq("reset_din", 32'(uart_din), 0);
        do_reset();

        // Single request on requester 2, done 20 cycles after send.
        set_byte(2, 8'hA5);
        req[2] = 1'b1;
        serve(20, 1'b0, 1'b0, 1'b0, k);
        req[2] = 1'b0;
        to_idle();
        tick();
        chk_eq("idle_busy", 32'(busy), 0);
        chk_eq("idle_send", 32'(uart_send), 0);

        // All four requesting continuously: strict rotation from requester 0.
        set_byte(0, 8'h11);
        set_byte(1, 8'h22);
        set_byte(2, 8'h33);
        set_byte(3, 8'h44);
        req = '1;
        do_reset();
        for (int i = 0; i < 8; i++) begin
            serve(3 + (i % 3), 1'b0, 1'b0, 1'b0, k);
            chk_eq("rr_order", 32'(gnt), i % N);
            to_idle();
        end

        // Requester 1 withdraws mid-SEND: byte completes, then 2 is next.
        serve(4, 1'b0, 1'b0, 1'b0, k);
        to_idle();
        serve(6, 1'b1, 1'b0, 1'b0, k);
        to_idle();
        serve(3, 1'b0, 1'b0, 1'b0, k);
        chk_eq("after_withdraw", 32'(gnt), 2);
        to_idle();

        // Reset five cycles into SEND; requester 0 is served first afterwards.
        req = '1;
        tick();
        chk_eq("pre_rst_send", 32'(uart_send), 1);
        repeat (4) tick();
        reset = 1'b1;
        tick();
        chk_eq("midrst_send", 32'(uart_send), 0);
        chk_eq("midrst_busy", 32'(busy), 0);
        chk_eq("midrst_ack", 32'(ack), 0);
        reset = 1'b0;
        m_last = N - 1;
        serve(5, 1'b0, 1'b0, 1'b0, k);
        chk_eq("post_rst_first", 32'(gnt), 0);
        req = '0;
        to_idle();

        // Spurious done in IDLE with nothing pending.
        tick();
        uart_done = 1'b1;
        tick();
        uart_done = 1'b0;
        chk_eq("spur_ack", 32'(ack), 0);
        chk_eq("spur_busy", 32'(busy), 0);
        chk_eq("spur_send", 32'(uart_send), 0);
        tick();
        req = '1;
        serve(2, 1'b0, 1'b0, 1'b0, k);
        chk_eq("spur_next", 32'(gnt), 1);
        to_idle();

`ifdef UART_ARB_LOCK_EN
        // Lock on requester 0 keeps the grant for three bytes, then moves on to 1.
        req = '1;
        lock = '0;
        lock[0] = 1'b1;
        do_reset();
        for (int i = 0; i < 4; i++) begin
            if (i == 2) lock[0] = 1'b0;
            serve(3, 1'b0, 1'b0, 1'b0, k);
            chk_eq("lock_gnt", 32'(gnt), (i < 3) ? 0 : 1);
            to_idle();
        end
        lock = '0;
`endif

        // Randomized traffic against the reference model.
        for (int it = 0; it < 60; it++) begin
            if (req == '0) begin
                if ($urandom_range(0, 2) == 0) begin
                    uart_done = 1'b1;
                    tick();
                    uart_done = 1'b0;
                    chk_eq("rnd_spur_busy", 32'(busy), 0);
                    chk_eq("rnd_spur_ack", 32'(ack), 0);
                end
                while (req == '0) begin
                    for (int j = 0; j < N; j++) begin
                        if ($urandom_range(0, 1) == 1) begin
                            set_byte(j, 8'($urandom));
                            req[j] = 1'b1;
                        end
                    end
                end
            end
            serve($urandom_range(1, 8), ($urandom_range(0, 5) == 0), 1'b1,
                  ($urandom_range(0, 3) == 0), k);
            if (req[k]) begin
                if ($urandom_range(0, 1) == 0) req[k] = 1'b0;
                else set_byte(k, 8'($urandom));
            end
            to_idle();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/uart_tx_arb.md
Name: uart_tx_arb

Overview:
- Round-robin arbiter and sequencer that shares one UART transmitter among N byte producers.
- Collects byte requests, grants one at a time and drives the transmitter's din/send pair.
- Holds send until the transmitter's done pulse, then acknowledges the winning requester.
- Sits between the producers (console, status reporter, debug dump, ...) and the uart block's TX inputs.

Parameters:
- N, 4, number of requesters (2..16).
- IdxW, 2, width of grant index; must satisfy 2**IdxW >= N.

Ports:
- clk  in  1  reference clock, same clock as the uart.
- reset  in  1  synchronous, active-high reset.
- req  in  [0:N-1]  per-requester request; held high with stable data until ack.
- data  in  [0:8*N-1]  flattened bytes; requester k uses bits [8k:8k+7], bit 8k transmitted first.
- ack  out  [0:N-1]  one-cycle pulse to requester k when its byte is fully sent.
- gnt  out  IdxW  index of current/last granted requester.
- busy  out  1  high while a byte is granted and in flight.
- uart_din  out  [0:7]  byte to the uart TX input.
- uart_send  out  1  uart send strobe, held until done.
- uart_done  in  1  uart done pulse (after stop bit).

Behaviour:
- Reset: all outputs low; gnt=0; last-served pointer=N-1, so requester 0 has first priority; state=IDLE.
- All outputs are registered.
- FSM states: IDLE, SEND, GAP.
- IDLE:
  - If any req bit is high, pick the first set bit searching from last+1 upward, wrapping mod N.
  - Latch data[8k:8k+7] into uart_din; set gnt=k, last=k, busy=1, uart_send=1; go to SEND.
  - Latency: req high at edge t gives uart_send high after edge t (visible in cycle t+1).
- SEND:
  - uart_send and uart_din held stable.
  - On uart_done=1: ack[gnt] pulses next cycle, uart_send=0, busy=0; go to GAP.
- GAP:
  - Exactly one cycle with uart_send low, so the transmitter sees a fresh send edge for the next byte.
  - Then go to IDLE.
  - ack is high during the GAP cycle.
- Back-to-back: a requester that updates data on the ack cycle is sampled in IDLE on the following cycle. Minimum spacing from uart_done to the next uart_send rise is 3 clk.
- req dropped mid-SEND: ignored; the byte completes and ack still pulses.
- uart_done in IDLE or GAP: ignored, with no state change.
- Data changes on a non-granted requester have no effect; only the latched copy is transmitted.
- Mask width: N not a power of two; the wrap uses explicit mod-N compare, never overflow of IdxW.
- Reset mid-SEND: returns to IDLE next cycle and drops uart_send. No ack is issued; the aborted requester keeps req high and is re-served normally, starting from requester 0 priority.
- Simultaneous requests: strictly round-robin. No requester is served twice while another has a pending req (unless the lock feature is active).

Optional Feature:
- Macro: UART_ARB_LOCK_EN.
- With the macro:
  - Adds input lock [0:N-1].
  - If lock[gnt] is high in the cycle uart_done is seen, last is not advanced and the next IDLE arbitration grants gnt first if its req is high. This allows multi-byte messages to go out unbroken.
  - If lock is high but req is low in IDLE, normal round-robin resumes.
- Without the macro: the port is absent and behaviour is pure round-robin.

Decomposition:
- Package uart_arb_pkg holds:
  - state enum typedef (IDLE, SEND, GAP);
  - constant BYTE_W=8;
  - a function returning the bit slice base 8*k.
- Sub-module uart_rr_pick: combinational round-robin selector.
  - Inputs: req vector and last index.
  - Outputs: valid and chosen index.
  - Parameterised by N and IdxW, reused by the RX dispatch path later.

Test Plan:
- Single request: req[2]=1, data byte2=8'hA5, uart_done pulsed 20 cycles after send.
  - uart_din=A5, gnt=2, uart_send high 1 cycle after req.
  - ack[2] one cycle after done; uart_send low for at least 1 cycle.
- All four requesting continuously with bytes 11,22,33,44.
  - Transmit order 11,22,33,44,11...
  - Each ack is a single pulse on the matching index.
- Requester 1 withdraws req mid-SEND.
  - Byte still completes; ack[1] pulses; next grant goes to 2 when pending.
- reset asserted 5 cycles into SEND.
  - uart_send=0, busy=0, ack=0 next cycle; requester 0 is served first afterwards.
- Spurious uart_done in IDLE with req=0.
  - No ack, no state change; busy stays 0.
- Lock (UART_ARB_LOCK_EN) with req=4'b1111 and lock[0]=1 for 3 bytes.
  - gnt stays 0 for 3 consecutive bytes, then proceeds to 1.
